// File: rtl/onehot_encoder.sv
// One-hot to binary encoder, two-stage valid/ready pipeline with a saturating
// count of erroneous (not exactly one-hot) results delivered downstream.
module onehot_encoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       number,
   output logic             err,
   input  logic             clear,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic       s1_valid;
   logic [7:0] s1_code;
   logic       s2_adv;
   logic       s1_adv;
   logic       in_fire;
   logic       deliver;
   logic [2:0] enc_number;
   logic       enc_err;
   logic       enc_found;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   assign in_ready = !s1_valid || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign deliver  = out_valid && out_ready;

   // Lowest set bit wins; more than one set bit or none at all flags an error.
   always_comb begin
      enc_number = '0;
      enc_found  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (s1_code[i] && !enc_found) begin
            enc_number = 3'(i);
            enc_found  = 1'b1;
         end
      end
      enc_err = !enc_found || ((s1_code & (s1_code - 8'd1)) != 8'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_code  <= code;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         number    <= '0;
         err       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            number <= enc_number;
            err    <= enc_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_count <= '0;
      end else if (deliver && err && (err_count != CNT_MAX)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_onehot_encoder.sv
// Self-checking bench for onehot_encoder: two instances (CNT_W=8 and CNT_W=2)
// share all inputs; results are scoreboarded against a behavioural encoder.
module tb_onehot_encoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] code;
   logic       out_ready;
   logic       clear;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] number;
   logic       err;
   logic [7:0] err_count8;
   logic       in_ready2;
   logic       out_valid2;
   logic [2:0] number2;
   logic       err2;
   logic [1:0] err_count2;

   onehot_encoder #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code(code),
      .out_valid(out_valid), .out_ready(out_ready), .number(number), .err(err),
      .clear(clear), .err_count(err_count8)
   );

   onehot_encoder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .code(code),
      .out_valid(out_valid2), .out_ready(out_ready), .number(number2), .err(err2),
      .clear(clear), .err_count(err_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int del_idx;
   int cnt8;
   int cnt2;
   logic [3:0] exp_q[$];
   logic [3:0] got_q[$];
   int         got_cyc[$];

   // Reference: {number, err}; number is log2 of the isolated lowest set bit.
   function automatic logic [3:0] ref_enc(input logic [7:0] c);
      int lb;
      int n;
      logic e;
      if (c == 8'h00) return 4'b0001;
      lb = int'(c & (~c + 8'd1));
      n  = $clog2(lb);
      e  = ($countones(c) != 1);
      return {3'(n), e};
   endfunction

   task automatic start_test();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
      del_idx = 0;
   endtask

   task automatic cycle(input logic iv, input logic [7:0] c, input logic ordy, input logic clr,
                        output logic acc, output logic [4:0] obs);
      logic del_err;
      in_valid  = iv;
      code      = c;
      out_ready = ordy;
      clear     = clr;
      #1;
      acc     = in_valid & in_ready;
      obs     = {out_valid, number, err};
      del_err = 1'b0;
      if (out_valid && out_ready) begin
         got_q.push_back({number, err});
         got_cyc.push_back(cyc);
         if (del_idx < exp_q.size()) del_err = exp_q[del_idx][0];
         del_idx++;
      end
      if (clr) begin
         cnt8 = 0;
         cnt2 = 0;
      end else if (del_err) begin
         if (cnt8 < 255) cnt8++;
         if (cnt2 < 3) cnt2++;
      end
      if (acc) exp_q.push_back(ref_enc(c));
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      logic acc;
      logic [4:0] obs;
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, obs);
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      code      = 8'hFF;
      out_ready = 1'b1;
      clear     = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cnt8      = 0;
      cnt2      = 0;
      start_test();
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if ({number, err} !== 4'b0000) $display("FAIL reset_number_err got %b want 0000", {number, err}); else passed++;
      total++; if (err_count8 !== 8'd0) $display("FAIL reset_err_count8 got %0d want 0", err_count8); else passed++;
      total++; if (err_count2 !== 2'd0) $display("FAIL reset_err_count2 got %0d want 0", err_count2); else passed++;
   endtask

   task automatic test_single();
      logic acc;
      logic [4:0] obs;
      start_test();
      cycle(1'b1, 8'h20, 1'b1, 1'b0, acc, obs);
      total++; if (acc !== 1'b1) $display("FAIL single_accept got %b want 1", acc); else passed++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, obs);
      total++; if ({out_valid, number, err} !== {1'b1, 3'd5, 1'b0})
         $display("FAIL single_latency got v=%b n=%0d e=%b want v=1 n=5 e=0", out_valid, number, err);
      else passed++;
      drain();
      total++; if (err_count8 !== 8'd0) $display("FAIL single_err_count got %0d want 0", err_count8); else passed++;
   endtask

   task automatic test_errors();
      logic acc;
      logic [4:0] obs;
      apply_reset();
      cycle(1'b1, 8'h00, 1'b1, 1'b0, acc, obs);
      cycle(1'b1, 8'h48, 1'b1, 1'b0, acc, obs);
      drain();
      total++; if (got_q.size() != 2) $display("FAIL errors_count got %0d want 2", got_q.size()); else passed++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] !== exp_q[i]) $display("FAIL errors_result[%0d] got %b want %b", i, got_q[i], exp_q[i]); else passed++;
      end
      total++; if (exp_q.size() == 2 && (exp_q[0] !== 4'b0001 || exp_q[1] !== 4'b0111))
         $display("FAIL errors_model got %b %b want 0001 0111", exp_q[0], exp_q[1]);
      else passed++;
      total++; if (err_count8 !== 8'd2) $display("FAIL errors_err_count got %0d want 2", err_count8); else passed++;
   endtask

   task automatic test_back_to_back();
      logic acc;
      logic [4:0] obs;
      logic [7:0] c;
      int refused = 0;
      start_test();
      for (int i = 0; i < 8; i++) begin
         c = 8'h01 << i;
         cycle(1'b1, c, 1'b1, 1'b0, acc, obs);
         if (!acc) refused++;
      end
      drain();
      total++; if (refused != 0) $display("FAIL b2b_in_ready got %0d refusals want 0", refused); else passed++;
      total++; if (got_q.size() != 8) $display("FAIL b2b_count got %0d want 8", got_q.size()); else passed++;
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         total++;
         if (got_q[i] !== {3'(i), 1'b0} || got_cyc[i] != got_cyc[0] + i)
            $display("FAIL b2b_result[%0d] got %b at +%0d want %b at +%0d", i, got_q[i], got_cyc[i] - got_cyc[0], {3'(i), 1'b0}, i);
         else passed++;
      end
   endtask

   task automatic test_stall();
      logic acc;
      logic [4:0] obs;
      logic [7:0] w[6];
      int idx = 0;
      int held_bad = 0;
      int guard = 0;
      start_test();
      for (int i = 0; i < 6; i++) w[i] = 8'h01 << $urandom_range(0, 7);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, w[idx], 1'b0, 1'b0, acc, obs);
         if (acc) idx++;
         if (k >= 2 && obs !== {1'b1, ref_enc(w[0])}) held_bad++;
      end
      total++; if (idx != 2) $display("FAIL stall_accepts got %0d want 2", idx); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else passed++;
      total++; if (held_bad != 0) $display("FAIL stall_hold got %0d unstable cycles want 0", held_bad); else passed++;
      while (idx < 6 && guard < 20) begin
         cycle(1'b1, w[idx], 1'b1, 1'b0, acc, obs);
         if (acc) idx++;
         guard++;
      end
      drain();
      total++; if (got_q.size() != 6) $display("FAIL stall_count got %0d want 6", got_q.size()); else passed++;
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         total++; if (got_q[i] !== ref_enc(w[i])) $display("FAIL stall_result[%0d] got %b want %b", i, got_q[i], ref_enc(w[i])); else passed++;
      end
   endtask

   task automatic test_saturation();
      logic acc;
      logic [4:0] obs;
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, (i % 2 == 0) ? 8'h00 : 8'hC3, 1'b1, 1'b0, acc, obs);
      drain();
      total++; if (err_count2 !== 2'd3) $display("FAIL sat_err_count2 got %0d want 3", err_count2); else passed++;
      total++; if (err_count8 !== 8'd5) $display("FAIL sat_err_count8 got %0d want 5", err_count8); else passed++;
      cycle(1'b1, 8'h00, 1'b0, 1'b0, acc, obs);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, obs);
      total++; if (out_valid !== 1'b1) $display("FAIL sat_pending got %b want 1", out_valid); else passed++;
      cycle(1'b0, 8'h00, 1'b1, 1'b1, acc, obs);
      total++; if (err_count2 !== 2'd0) $display("FAIL sat_clear_wins2 got %0d want 0", err_count2); else passed++;
      total++; if (err_count8 !== 8'd0) $display("FAIL sat_clear_wins8 got %0d want 0", err_count8); else passed++;
      drain();
   endtask

   task automatic test_reset_flight();
      logic acc;
      logic [4:0] obs;
      apply_reset();
      cycle(1'b1, 8'h05, 1'b1, 1'b0, acc, obs);
      drain();
      cycle(1'b1, 8'h00, 1'b0, 1'b0, acc, obs);
      cycle(1'b1, 8'h0C, 1'b0, 1'b0, acc, obs);
      total++; if (in_ready !== 1'b0 || err_count8 !== 8'd1)
         $display("FAIL flight_setup got rdy=%b cnt=%0d want rdy=0 cnt=1", in_ready, err_count8);
      else passed++;
      apply_reset();
      total++; if (out_valid !== 1'b0) $display("FAIL flight_out_valid got %b want 0", out_valid); else passed++;
      total++; if (err_count8 !== 8'd0) $display("FAIL flight_err_count got %0d want 0", err_count8); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL flight_in_ready got %b want 1", in_ready); else passed++;
      drain();
      total++; if (got_q.size() != 0) $display("FAIL flight_discard got %0d deliveries want 0", got_q.size()); else passed++;
   endtask

   task automatic test_random();
      logic acc;
      logic [4:0] obs;
      logic [7:0] c;
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0, 3:    c = 8'h01 << $urandom_range(0, 7);
            1:       c = 8'h00;
            default: c = 8'($urandom);
         endcase
         cycle(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), acc, obs);
      end
      drain();
      total++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_result[%0d] got %b want %b", i, got_q[i], exp_q[i]); else passed++;
      end
      total++; if (err_count8 !== 8'(cnt8)) $display("FAIL rand_err_count8 got %0d want %0d", err_count8, cnt8); else passed++;
      total++; if (err_count2 !== 2'(cnt2)) $display("FAIL rand_err_count2 got %0d want %0d", err_count2, cnt2); else passed++;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      code      = 8'h00;
      out_ready = 1'b0;
      clear     = 1'b0;
      cnt8      = 0;
      cnt2      = 0;
      del_idx   = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_errors();
      test_back_to_back();
      test_stall();
      test_saturation();
      test_reset_flight();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
